// File: rtl/sar_target_finder.sv
// rtl/sar_target_finder.sv - successive-approximation search driving a magnitude comparator
// Probes MSB first from the comparator's eq/ne/gt/lt/ge/le flags to recover its in2 operand.
module sar_target_finder #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [5:0]                   flags_in,
  output logic [WIDTH-1:0]             probe,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic                         error,
  output logic [$clog2(WIDTH+1)-1:0]   steps
);

  localparam int SW = $clog2(WIDTH+1);
  localparam int KW = $clog2(WIDTH);
  localparam logic [5:0] F_EQ = 6'b110001;
  localparam logic [5:0] F_LT = 6'b101010;
  localparam logic [5:0] F_GT = 6'b010110;

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] nxt_bit;
  logic             is_lt;
  logic             is_gt;
  logic             fin;

  assign is_lt   = (flags_in == F_LT);
  assign is_gt   = (flags_in == F_GT);
  assign nxt_bit = {{(WIDTH-1){1'b0}}, 1'b1} << (k - KW'(1));
  // Anything other than a mid-search LT/GT ends the search on this edge.
  assign fin     = (state == SEARCH) && !((is_lt || is_gt) && (k != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      probe  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      error  <= 1'b0;
      steps  <= '0;
      acc    <= '0;
      k      <= KW'(WIDTH-1);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          probe <= '0;
          busy  <= 1'b0;
          if (start) begin
            state <= SEARCH;
            acc   <= '0;
            error <= 1'b0;
            steps <= '0;
            k     <= KW'(WIDTH-1);
            probe <= {1'b1, {(WIDTH-1){1'b0}}};
            busy  <= 1'b1;
          end
        end
        SEARCH: begin
          steps <= steps + SW'(1);
          if (flags_in == F_EQ) begin
            result <= probe;
          end else if (is_lt && (k != '0)) begin
            acc   <= probe;
            k     <= k - KW'(1);
            probe <= probe | nxt_bit;
          end else if (is_gt && (k != '0)) begin
            k     <= k - KW'(1);
            probe <= acc | nxt_bit;
          end else if (is_gt) begin
            result <= acc;
          end else begin
            // Illegal vector, or LT on the last bit (target cannot exceed the final probe).
            error  <= 1'b1;
            result <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        state <= IDLE;
        done  <= 1'b1;
        busy  <= 1'b0;
        probe <= '0;
      end
    end
  end

endmodule

// File: doc/sar_target_finder.md
Name: sar_target_finder

Overview:
- Sequential initiator for the 6-bit relational-flag interface produced by the team's magnitude comparator.
- Drives the comparator's in1 operand with a probe value, with in2 wired to an unknown target.
- Reads back the flag vector and binary-searches, successive-approximation style, MSB first, to recover the target.
- Used for threshold discovery and as a closed-loop self-check of the comparator.

Parameters:
- WIDTH, 4, operand width of probe, target and result; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- flags_in  input  6  comparator flags for (in1=probe, in2=target). Bit map: [0] eq, [1] ne, [2] gt, [3] lt, [4] ge, [5] le.
- probe  output  WIDTH  registered value driven to comparator in1.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when a search finishes.
- result  output  WIDTH  recovered target; held until the next accepted start.
- error  output  1  set with done when a flag vector is illegal or contradictory; held with result.
- steps  output  $clog2(WIDTH+1)  number of probes evaluated in the last search; held.

Behaviour:
- Reset:
  - On a clk edge with rst_n=0, all of the following clear: state=IDLE, probe=0, busy=0, done=0, result=0, error=0, steps=0, accumulator acc=0, bit index k=WIDTH-1.
  - Reset mid-search aborts the search with no done pulse.
- Decoding of flags_in (6-bit value):
  - 6'b110001 = EQ.
  - 6'b101010 = LT (probe < target).
  - 6'b010110 = GT (probe > target).
  - Every other value is ILLEGAL.
- IDLE:
  - probe=0, busy=0.
  - start=1 → SEARCH. Clear acc, error and steps; set k=WIDTH-1; probe=1<<(WIDTH-1); busy=1.
- SEARCH:
  - Each edge samples flags_in for the current probe, which is always acc|(1<<k), and increments steps.
  - EQ: result=probe, then finish.
  - LT: acc=probe.
  - GT: acc unchanged.
  - If k>0 (LT or GT): k=k-1; the next probe is the updated acc|(1<<(k-1)).
  - If k==0 with GT: result=acc, then finish.
  - If k==0 with LT: the response is contradictory. Set error=1, result=0, then finish.
  - ILLEGAL at any k: set error=1, result=0, then finish.
- Finish, on the same edge as the last sample:
  - state=IDLE, done=1 for exactly one cycle, busy=0, probe=0.
- Latency:
  - The first sample occurs on the edge after the start-accept edge.
  - done is asserted between 1 and WIDTH samples after that, i.e. at most WIDTH cycles after busy rises.
- start handling:
  - start while busy is ignored.
  - start in the same cycle that done is high is accepted on the next edge; the state is IDLE by then.
- External comparator timing: it must be combinational with respect to probe. flags_in must be valid within the cycle in which probe is presented.
- Arithmetic: all values are unsigned. No operand wraps, because probes stay within 0..2^WIDTH-1.

Test Plan:
- Target 9 (WIDTH=4), start pulse → probes 8(LT), 12(GT), 10(GT), 9(EQ); done pulse with result=9, steps=4, error=0; busy high for exactly 4 cycles.
- Target 8 → single probe 8 returns EQ; done one cycle after the start-accept edge; result=8, steps=1.
- Targets 0 and 15 → probes 8,4,2,1 all GT giving result=0, steps=4; and probes 8,12,14,15 giving result=15, steps=4. Sweep all 16 targets and check result==target every time.
- Force flags_in=6'h3F on the second probe → done with error=1, result=0, steps=2. Separately, force LT on every probe → error=1 at k=0, steps=4.
- Assert rst_n=0 for one cycle during the third probe → next cycle probe=0, busy=0, done never pulses. A new start with target 5 then yields result=5.
- Pulse start again while busy → ignored; the search completes unchanged. start asserted concurrently with done → a second search begins, and the first result stays held until it finishes.
